alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Two-requester round-robin arbiter and sequencer for one shared `alu` instance, owned internally. It accepts operations over valid/ready request channels and registers operands. It drives the ALU for one execute cycle, captures Result and the four flags, and returns them on a one-hot response channel. It sits between the execute stage (port 0) and the auxiliary/debug compute path (port 1), so both share a single ALU.

## Interface
- RR_INIT, 0 — port holding priority after reset (0 or 1)
- CNT_W, 16 — width of the completed-operation counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request present on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle (per port)
- req0_a, req0_b / req1_a, req1_b  in  32  operands A, B
- req0_ctrl / req1_ctrl  in  4  ALUControl code (0000 ADD … 1001 SRA)
- rsp_valid  out  2  one-hot: bit n = response for port n
- rsp_ready  in  2  bit n = port n consumes response
- rsp_result  out  32  captured ALU Result
- rsp_flags  out  4  {Carry, OverFlow, Zero, Negative} captured
- rsp_err  out  1  ctrl code was 1010–1111
- busy  out  1  state != IDLE
- ops_done  out  CNT_W  completed responses, wraps modulo 2^CNT_W

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - if no reqN_valid, stay.
  - else grant: if both valid, prio port wins; if one valid, that port wins.
  - reqN_ready = 1 combinationally for the granted port only, and only in IDLE.
  - latch a, b, ctrl, and grant id; prio <= the non-granted port (1 - grant); go EXEC.
- EXEC:
  - ALU inputs come from latched registers only, never from live request ports.
  - capture Result and flags into the rsp registers.
  - if latched ctrl >= 1010: rsp_result = 0, rsp_flags = 0, rsp_err = 1; otherwise rsp_err = 0.
  - go RESP.
- RESP:
  - rsp_valid[grant] = 1, other bit 0.
  - result, flags, and err are held stable until the handshake.
  - on rsp_ready[grant] = 1: ops_done += 1 (wraps), go IDLE.
  - rsp_ready on the non-granted bit is ignored.
- ALU flag semantics are passed through unmodified from `alu`. SUB Carry = 1 means no borrow.
- Requests arriving while busy are not accepted. reqN_ready = 0; the requester must hold valid and data stable.
- Reset, asserted any time, including mid-EXEC/RESP:
  - state = IDLE, prio = RR_INIT, all latches 0, rsp_valid = 00, rsp_result = 0, rsp_flags = 0, rsp_err = 0, ops_done = 0, busy = 0.
  - any in-flight operation is dropped with no response.

## Timing
- Accept edge = cycle 0, the clock edge where valid & ready.
- EXEC occupies cycle 1; rsp_valid rises after the cycle-1 edge (visible cycle 2).
- Minimum request-to-response latency: 2 cycles. Minimum issue interval: 3 cycles (accept, EXEC, RESP with immediate rsp_ready).
- Back-to-back: after the RESP handshake edge, the next grant can happen in the following IDLE cycle. There is no accept in the same cycle as the handshake.
- Response stall: rsp_valid stays high indefinitely while rsp_ready[grant] = 0. No timeout.
- Outputs are registered except reqN_ready and busy, which decode state combinationally.

## Test plan
- Reset, then port 0 ADD 0x00000005 + 0x00000007 (ctrl 0000):
  - req0_ready high at accept; rsp_valid = 01 two cycles later.
  - rsp_result = 0x0000000C, flags = 0000, err = 0, ops_done = 1.
- Both ports valid each cycle with RR_INIT = 0:
  - port 0 is SUB 0x80000000 − 0x00000001; port 1 is SLT 0xFFFFFFFB, 0x00000005.
  - grants alternate 0, 1, 0, 1.
  - port 0 responses: 0x7FFFFFFF, flags 1100 (Carry = 1, OverFlow = 1).
  - port 1 responses: 0x00000001, flags 0000.
- Port 1 ADD 0xFFFFFFFF + 0x00000001, rsp_ready held 0 for 5 cycles:
  - rsp_valid = 10 and rsp_result = 0x00000000 with flags 1010, both stable throughout.
  - req0_valid during the stall sees req0_ready = 0.
  - completes on rsp_ready = 10.
- Port 0 ctrl 1111, A = 0x12345678:
  - rsp_err = 1, result 0, flags 0000, latency 2.
  - following SRA 0x80000000 >> 31 (ctrl 1001) returns 0xFFFFFFFF, flags 0001, err = 0.
- rst_n pulsed low during EXEC:
  - all outputs return to reset values immediately (asynchronous).
  - no response is issued for the dropped operation; ops_done = 0.
  - next grant follows RR_INIT priority.
- Force ops_done to 2^CNT_W − 1 with CNT_W = 4 (15 completions), then one more op → ops_done = 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one 32-bit ALU between two request ports.
// Each operation takes three cycles: accept, execute on latched operands, respond.
`timescale 1ns/1ps

module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  ctrl,
  output logic [31:0] result,
  output logic        carry,
  output logic        overflow,
  output logic        zero,
  output logic        negative
);
  logic [32:0] sum;
  logic [32:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Subtraction as a + ~b + 1, so the carry out means "no borrow".
  assign diff = {1'b0, a} + {1'b0, ~b} + 33'd1;

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (ctrl)
      4'h0: begin
        result   = sum[31:0];
        carry    = sum[32];
        overflow = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      4'h1: begin
        result   = diff[31:0];
        carry    = diff[32];
        overflow = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      4'h2: result = a & b;
      4'h3: result = a | b;
      4'h4: result = a ^ b;
      4'h5: result = {31'd0, ($signed(a) < $signed(b))};
      4'h6: result = {31'd0, (a < b)};
      4'h7: result = a << b[4:0];
      4'h8: result = a >> b[4:0];
      4'h9: result = $unsigned($signed(a) >>> b[4:0]);
      default: result = '0;
    endcase
  end

  assign zero     = (result == 32'd0);
  assign negative = result[31];
endmodule

module alu_share_arbiter #(
  parameter logic RR_INIT = 1'b0,
  parameter int   CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [3:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [3:0]       req1_ctrl,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic               prio_q, prio_d;
  logic               grant_q, grant_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic [1:0]         rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_result_q, rsp_result_d;
  logic [3:0]         rsp_flags_q, rsp_flags_d;
  logic               rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]   ops_done_q, ops_done_d;

  logic               grant_sel;
  logic               req_any;
  logic [31:0]        alu_result;
  logic               alu_c, alu_v, alu_z, alu_n;

  // The ALU only ever sees latched operands, so live requesters cannot disturb EXEC.
  alu u_alu (
    .a(a_q), .b(b_q), .ctrl(ctrl_q),
    .result(alu_result), .carry(alu_c), .overflow(alu_v), .zero(alu_z), .negative(alu_n)
  );

  assign req_any   = req0_valid | req1_valid;
  assign grant_sel = (req0_valid && req1_valid) ? prio_q : req1_valid;
  assign req0_ready = (state_q == IDLE) && req_any && !grant_sel;
  assign req1_ready = (state_q == IDLE) && req_any &&  grant_sel;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    grant_d      = grant_q;
    a_d          = a_q;
    b_d          = b_q;
    ctrl_d       = ctrl_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    ops_done_d   = ops_done_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          grant_d = grant_sel;
          prio_d  = !grant_sel;
          a_d     = grant_sel ? req1_a    : req0_a;
          b_d     = grant_sel ? req1_b    : req0_b;
          ctrl_d  = grant_sel ? req1_ctrl : req0_ctrl;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_valid_d = grant_q ? 2'b10 : 2'b01;
        if (ctrl_q >= 4'hA) begin
          rsp_result_d = '0;
          rsp_flags_d  = '0;
          rsp_err_d    = 1'b1;
        end else begin
          rsp_result_d = alu_result;
          rsp_flags_d  = {alu_c, alu_v, alu_z, alu_n};
          rsp_err_d    = 1'b0;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready[grant_q]) begin
          rsp_valid_d = 2'b00;
          ops_done_d  = ops_done_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prio_q       <= RR_INIT;
      grant_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      ctrl_q       <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      grant_q      <= grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ctrl_q       <= ctrl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign ops_done   = ops_done_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with hand-computed expected values.
`timescale 1ns/1ps

module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_ctrl = '0, req1_ctrl = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err, busy;
  logic [3:0]  ops_done;

  int vecs = 0;
  int errs = 0;

  logic [31:0] got_res;
  logic [3:0]  got_flags;
  logic        got_err;
  logic [1:0]  got_valid;
  logic        got_rdy;
  int          got_lat;

  always #5 clk = ~clk;

  alu_share_arbiter #(.RR_INIT(1'b0), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .busy(busy), .ops_done(ops_done)
  );

  // Issues one op on a port and completes it; entered and left 1ns after a rising edge.
  task automatic run_op(input int port, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] ctrl);
    int w;
    if (port == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = ctrl;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = ctrl;
    end
    #1;
    w = 0;
    while (!((port == 0) ? req0_ready : req1_ready) && w < 10) begin
      @(posedge clk); #1; w++;
    end
    got_rdy = (port == 0) ? req0_ready : req1_ready;
    @(posedge clk); #1;
    if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    got_lat = 1;
    while (rsp_valid == 2'b00 && got_lat < 10) begin
      @(posedge clk); #1; got_lat++;
    end
    got_valid = rsp_valid; got_res = rsp_result; got_flags = rsp_flags; got_err = rsp_err;
    $display("op port=%0d ctrl=%h a=%h b=%h -> valid=%b result=%h flags=%b err=%b lat=%0d",
             port, ctrl, a, b, got_valid, got_res, got_flags, got_err, got_lat);
    rsp_ready = (port == 0) ? 2'b01 : 2'b10;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vecs++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vecs++; if (ops_done !== 4'd0) begin errs++; $display("FAIL reset_ops_done got=%0d exp=0", ops_done); end
    vecs++; if ({rsp_result, rsp_flags, rsp_err} !== 37'd0) begin errs++; $display("FAIL reset_rsp_regs got=%h/%b/%b exp=0", rsp_result, rsp_flags, rsp_err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_add();
    run_op(0, 32'h5, 32'h7, 4'h0);
    vecs++; if (got_rdy !== 1'b1) begin errs++; $display("FAIL add_ready got=%b exp=1", got_rdy); end
    vecs++; if (got_valid !== 2'b01) begin errs++; $display("FAIL add_rsp_valid got=%b exp=01", got_valid); end
    vecs++; if (got_lat !== 2) begin errs++; $display("FAIL add_latency got=%0d exp=2", got_lat); end
    vecs++; if (got_res !== 32'h0000000C) begin errs++; $display("FAIL add_result got=%h exp=0000000c", got_res); end
    vecs++; if (got_flags !== 4'b0000 || got_err !== 1'b0) begin errs++; $display("FAIL add_flags got=%b/%b exp=0000/0", got_flags, got_err); end
    vecs++; if (ops_done !== 4'd1) begin errs++; $display("FAIL add_ops_done got=%0d exp=1", ops_done); end
    vecs++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin errs++; $display("FAIL add_idle got=%b/%b exp=00/0", rsp_valid, busy); end
  endtask

  task automatic test_alternate();
    int w;
    int g;
    do_reset();
    req0_valid = 1'b1; req0_a = 32'h80000000; req0_b = 32'h00000001; req0_ctrl = 4'h1;
    req1_valid = 1'b1; req1_a = 32'hFFFFFFFB; req1_b = 32'h00000005; req1_ctrl = 4'h5;
    #1;
    for (int i = 0; i < 4; i++) begin
      w = 0;
      while (!(req0_ready || req1_ready) && w < 10) begin @(posedge clk); #1; w++; end
      g = req1_ready ? 1 : 0;
      vecs++; if (g !== (i % 2)) begin errs++; $display("FAIL alt_grant[%0d] got=%0d exp=%0d", i, g, i % 2); end
      @(posedge clk); #1;
      w = 0;
      while (rsp_valid == 2'b00 && w < 10) begin @(posedge clk); #1; w++; end
      $display("alt op %0d grant=%0d valid=%b result=%h flags=%b", i, g, rsp_valid, rsp_result, rsp_flags);
      if (i % 2 == 0) begin
        vecs++; if (rsp_valid !== 2'b01 || rsp_result !== 32'h7FFFFFFF || rsp_flags !== 4'b1100) begin
          errs++; $display("FAIL alt_sub[%0d] got=%b/%h/%b exp=01/7fffffff/1100", i, rsp_valid, rsp_result, rsp_flags); end
      end else begin
        vecs++; if (rsp_valid !== 2'b10 || rsp_result !== 32'h00000001 || rsp_flags !== 4'b0000) begin
          errs++; $display("FAIL alt_slt[%0d] got=%b/%h/%b exp=10/00000001/0000", i, rsp_valid, rsp_result, rsp_flags); end
      end
      rsp_ready = 2'b11;
      @(posedge clk); #1;
      rsp_ready = 2'b00;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    vecs++; if (ops_done !== 4'd4) begin errs++; $display("FAIL alt_ops_done got=%0d exp=4", ops_done); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int w;
    req1_valid = 1'b1; req1_a = 32'hFFFFFFFF; req1_b = 32'h00000001; req1_ctrl = 4'h0;
    #1;
    w = 0;
    while (!req1_ready && w < 10) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    w = 0;
    while (rsp_valid == 2'b00 && w < 10) begin @(posedge clk); #1; w++; end
    $display("stall op valid=%b result=%h flags=%b", rsp_valid, rsp_result, rsp_flags);
    vecs++; if (rsp_valid !== 2'b10 || rsp_result !== 32'h0 || rsp_flags !== 4'b1010) begin
      errs++; $display("FAIL stall_first got=%b/%h/%b exp=10/00000000/1010", rsp_valid, rsp_result, rsp_flags); end
    req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h1; req0_ctrl = 4'h0;
    rsp_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vecs++; if (rsp_valid !== 2'b10 || rsp_result !== 32'h0 || rsp_flags !== 4'b1010) begin
        errs++; $display("FAIL stall_hold[%0d] got=%b/%h/%b exp=10/00000000/1010", i, rsp_valid, rsp_result, rsp_flags); end
      vecs++; if (req0_ready !== 1'b0) begin errs++; $display("FAIL stall_req0_ready[%0d] got=%b exp=0", i, req0_ready); end
    end
    rsp_ready = 2'b10;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    req0_valid = 1'b0;
    vecs++; if (rsp_valid !== 2'b00 || ops_done !== 4'd5) begin errs++; $display("FAIL stall_done got=%b/%0d exp=00/5", rsp_valid, ops_done); end
    #1;
  endtask

  task automatic test_invalid_ctrl();
    run_op(0, 32'h12345678, 32'h00000003, 4'hF);
    vecs++; if (got_err !== 1'b1 || got_res !== 32'h0 || got_flags !== 4'b0000) begin
      errs++; $display("FAIL bad_ctrl got=%b/%h/%b exp=1/00000000/0000", got_err, got_res, got_flags); end
    vecs++; if (got_lat !== 2 || got_valid !== 2'b01) begin errs++; $display("FAIL bad_ctrl_timing got=%0d/%b exp=2/01", got_lat, got_valid); end
    run_op(0, 32'h80000000, 32'd31, 4'h9);
    vecs++; if (got_err !== 1'b0 || got_res !== 32'hFFFFFFFF || got_flags !== 4'b0001) begin
      errs++; $display("FAIL sra got=%b/%h/%b exp=0/ffffffff/0001", got_err, got_res, got_flags); end
  endtask

  task automatic test_reset_exec();
    int w;
    req0_valid = 1'b1; req0_a = 32'h3; req0_b = 32'h4; req0_ctrl = 4'h0;
    #1;
    w = 0;
    while (!req0_ready && w < 10) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL rexec_busy got=%b exp=1", busy); end
    #2; rst_n = 1'b0; #1;
    $display("reset pulsed during EXEC");
    vecs++; if (rsp_valid !== 2'b00 || busy !== 1'b0 || ops_done !== 4'd0) begin
      errs++; $display("FAIL rexec_ctrl got=%b/%b/%0d exp=00/0/0", rsp_valid, busy, ops_done); end
    vecs++; if (rsp_result !== 32'h0 || rsp_flags !== 4'h0 || rsp_err !== 1'b0) begin
      errs++; $display("FAIL rexec_data got=%h/%b/%b exp=0/0/0", rsp_result, rsp_flags, rsp_err); end
    #1; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vecs++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL rexec_no_rsp[%0d] got=%b exp=00", i, rsp_valid); end
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    vecs++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errs++; $display("FAIL rexec_prio got=%b%b exp=01", req1_ready, req0_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 15; i++) run_op(i % 2, 32'(i), 32'h1, 4'h0);
    vecs++; if (ops_done !== 4'd15) begin errs++; $display("FAIL wrap_15 got=%0d exp=15", ops_done); end
    run_op(0, 32'h10, 32'h20, 4'h0);
    vecs++; if (ops_done !== 4'd0) begin errs++; $display("FAIL wrap_0 got=%0d exp=0", ops_done); end
    vecs++; if (got_res !== 32'h30) begin errs++; $display("FAIL wrap_result got=%h exp=00000030", got_res); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alternate();
    test_stall();
    test_invalid_ctrl();
    test_reset_exec();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
